// File: rtl/io_hsk_port_pkg.sv
// ---------------------------------------------------------------------------
// io_hsk_defs
//   Shared definitions for the processor I/O handshake port.
//   Holds the core-side FSM state encoding used by io_hsk_port and
//   by anything that observes its debug state output.
// ---------------------------------------------------------------------------
package io_hsk_defs;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_ACK  = 2'd1;
    localparam logic [1:0] S_RD_ACK  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_WR_ACK  = S_WR_ACK,
        ST_RD_ACK  = S_RD_ACK,
        ST_RELEASE = S_RELEASE
    } hsk_state_t;

endpackage

// File: rtl/io_hsk_port_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
//   Small circular FIFO with occupancy count. Full/empty are decoded from
//   the registered count, so they never depend on this cycle's push/pop.
//   The head (o_dout) is read from storage at the registered read pointer,
//   so a push into an empty FIFO appears on o_dout the following cycle.
// Ports
//   g_clk    in   clock, rising edge
//   g_clr    in   asynchronous active-high clear
//   i_push   in   write i_din (ignored when full)
//   i_pop    in   drop the head entry (ignored when empty)
//   i_din    in   write data
//   o_dout   out  head entry
//   o_count  out  occupancy 0..DEPTH
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 4,
    parameter int A_WIDTH = 2
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [D_WIDTH-1:0] i_din,
    output logic [D_WIDTH-1:0] o_dout,
    output logic [A_WIDTH:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam logic [A_WIDTH:0] L_DEPTH = (A_WIDTH+1)'(DEPTH);

    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_rd_ptr;
    logic [A_WIDTH:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == L_DEPTH);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is cleared too so the head reads 0 straight out of reset.
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;  // DEPTH is a power of 2: wraps naturally
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_hsk_port.sv
// ---------------------------------------------------------------------------
// io_hsk_port
//   Byte-stream I/O port on the processor's bus_in/bus_out/hsk_in/hsk_out
//   pins. The host side uses valid/ready streams, the core side a
//   four-phase req/ack handshake. RX FIFO feeds core IN transfers,
//   TX FIFO collects core OUT transfers.
//
//   Handshake rules:
//     host streams : a byte moves on a rising edge where valid & ready are
//                    both 1; ready/valid driven by the port depend only on
//                    registered FIFO counts.
//     core         : req rises -> ack rises one cycle later if the FIFO
//                    allows; req falls -> ack falls one cycle later; one
//                    idle (RELEASE) cycle follows before a new request.
// Ports
//   g_clk, g_clr          clock, asynchronous active-high reset
//   proc_req/proc_wr      core request and direction (1=OUT, 0=IN)
//   proc_dout             core output byte (bus_out)
//   proc_ack/proc_din     acknowledge (hsk_in) and byte to core (bus_in)
//   rx_data/valid/ready   host -> core stream
//   tx_data/valid/ready   core -> host stream
//   rx_count/tx_count     FIFO occupancies
//   dbg_state             core FSM state
// ---------------------------------------------------------------------------
module io_hsk_port
    import io_hsk_defs::*;
#(
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 4,
    parameter int A_WIDTH = 2
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               proc_req,
    input  logic               proc_wr,
    input  logic [D_WIDTH-1:0] proc_dout,
    output logic               proc_ack,
    output logic [D_WIDTH-1:0] proc_din,
    input  logic [D_WIDTH-1:0] rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [D_WIDTH-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [A_WIDTH:0]   rx_count,
    output logic [A_WIDTH:0]   tx_count,
    output logic [1:0]         dbg_state
);

    hsk_state_t         r_state;
    hsk_state_t         w_state_nxt;
    logic               r_ack;
    logic [D_WIDTH-1:0] r_din;
    logic               w_tx_push;
    logic               w_rx_pop;
    logic               w_din_load;
    logic [D_WIDTH-1:0] w_rx_head;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_tx_full;
    logic               w_tx_empty;

    byte_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH), .A_WIDTH(A_WIDTH)) u_rx_fifo (
        .g_clk   (g_clk),
        .g_clr   (g_clr),
        .i_push  (rx_valid),
        .i_pop   (w_rx_pop),
        .i_din   (rx_data),
        .o_dout  (w_rx_head),
        .o_count (rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    byte_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH), .A_WIDTH(A_WIDTH)) u_tx_fifo (
        .g_clk   (g_clk),
        .g_clr   (g_clr),
        .i_push  (w_tx_push),
        .i_pop   (tx_ready),
        .i_din   (proc_dout),
        .o_dout  (tx_data),
        .o_count (tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign rx_ready  = ~w_rx_full;
    assign tx_valid  = ~w_tx_empty;
    assign proc_ack  = r_ack;
    assign proc_din  = r_din;
    assign dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_tx_push   = 1'b0;
        w_rx_pop    = 1'b0;
        w_din_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A request the FIFO cannot serve simply waits here unacked.
                if (proc_req) begin
                    if (proc_wr) begin
                        if (!w_tx_full) begin
                            w_tx_push   = 1'b1;
                            w_state_nxt = ST_WR_ACK;
                        end
                    end else if (!w_rx_empty) begin
                        w_din_load  = 1'b1;
                        w_state_nxt = ST_RD_ACK;
                    end
                end
            end
            ST_WR_ACK: begin
                if (!proc_req) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RD_ACK: begin
                // The byte leaves RX only once the core has let go of it.
                if (!proc_req) begin
                    w_rx_pop    = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_din   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= (w_state_nxt == ST_WR_ACK) || (w_state_nxt == ST_RD_ACK);
            if (w_din_load) begin
                r_din <= w_rx_head;
            end
        end
    end

endmodule

// File: tb/tb_io_hsk_port.sv
module tb_io_hsk_port;
    import io_hsk_defs::*;

    localparam int W = 8;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic         g_clk = 1'b0;
    logic         g_clr;
    logic         proc_req, proc_wr;
    logic [W-1:0] proc_dout;
    logic         proc_ack;
    logic [W-1:0] proc_din;
    logic [W-1:0] rx_data;
    logic         rx_valid, rx_ready;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_ready;
    logic [2:0]   rx_count, tx_count;
    logic [1:0]   dbg_state;

    always #5 g_clk = ~g_clk;

    io_hsk_port #(.D_WIDTH(W), .DEPTH(DEPTH), .A_WIDTH(2)) dut (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .proc_req  (proc_req),
        .proc_wr   (proc_wr),
        .proc_dout (proc_dout),
        .proc_ack  (proc_ack),
        .proc_din  (proc_din),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_count  (rx_count),
        .tx_count  (tx_count),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] tx_exp_q[$];
    logic [W-1:0] rx_exp_q[$];
    int rx_cnt_m = 0;
    int tx_cnt_m = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge g_clk);
    endtask

    task automatic host_rx_push(input logic [W-1:0] d);
        check("rx_ready", {31'd0, rx_ready}, {31'd0, rx_cnt_m < DEPTH});
        rx_data  = d;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        if (rx_cnt_m < DEPTH) begin
            rx_exp_q.push_back(d);
            rx_cnt_m++;
        end
        check("rx_count", {29'd0, rx_count}, rx_cnt_m);
    endtask

    task automatic host_tx_pop();
        logic [W-1:0] e;
        e = tx_exp_q.pop_front();
        check("tx_valid", {31'd0, tx_valid}, 32'd1);
        check("tx_data", {24'd0, tx_data}, {24'd0, e});
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        tx_cnt_m--;
        check("tx_count_pop", {29'd0, tx_count}, tx_cnt_m);
    endtask

    // Full four-phase transfer; returns cycles from req rise to ack seen.
    task automatic core_xfer(input logic wr, input logic [W-1:0] d, output int lat);
        logic [W-1:0] got;
        logic [W-1:0] e;
        proc_wr   = wr;
        proc_dout = d;
        proc_req  = 1'b1;
        lat = 0;
        while (!proc_ack && lat < 40) begin
            step();
            lat++;
        end
        check("ack_rise", {31'd0, proc_ack}, 32'd1);
        check("ack_state", {30'd0, dbg_state}, {30'd0, wr ? S_WR_ACK : S_RD_ACK});
        got = proc_din;
        if (wr) begin
            tx_exp_q.push_back(d);
            tx_cnt_m++;
            check("tx_count_push", {29'd0, tx_count}, tx_cnt_m);
        end else begin
            e = rx_exp_q.pop_front();
            check("proc_din", {24'd0, got}, {24'd0, e});
        end
        // Changes while acked must be ignored.
        proc_wr   = ~wr;
        proc_dout = ~d;
        step();
        proc_req = 1'b0;
        step();
        check("ack_fall", {31'd0, proc_ack}, 32'd0);
        check("release", {30'd0, dbg_state}, {30'd0, S_RELEASE});
        if (!wr) begin
            rx_cnt_m--;
            check("rx_count_pop", {29'd0, rx_count}, rx_cnt_m);
        end
        step();
        check("idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic [W-1:0] rd;
        g_clr = 1'b1; proc_req = 1'b0; proc_wr = 1'b0; proc_dout = '0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) step();
        g_clr = 1'b0;
        step();

        // Put some state in, then reset mid-cycle and expect immediate clear.
        host_rx_push(8'h55);
        core_xfer(1'b1, 8'h66, lat);
        core_xfer(1'b0, 8'h00, lat);
        host_rx_push(8'h57);
        #2 g_clr = 1'b1;
        #1;
        check("rst_ack", {31'd0, proc_ack}, 32'd0);
        check("rst_din", {24'd0, proc_din}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_rx_count", {29'd0, rx_count}, 32'd0);
        check("rst_tx_count", {29'd0, tx_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        step();
        g_clr = 1'b0;
        tx_exp_q.delete(); rx_exp_q.delete(); rx_cnt_m = 0; tx_cnt_m = 0;
        step();

        // OUT transfer, then host drains it.
        core_xfer(1'b1, 8'hA5, lat);
        check("out_lat", lat, 32'd1);
        host_tx_pop();

        // IN stall on empty RX, released by a host push.
        proc_wr = 1'b0; proc_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_ack", {31'd0, proc_ack}, 32'd0);
        end
        rx_data = 8'h3C; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_exp_q.push_back(8'h3C); rx_cnt_m = 1;
        check("stall_rx_count", {29'd0, rx_count}, 32'd1);
        check("stall_ack_late", {31'd0, proc_ack}, 32'd0);
        step();
        check("stall_ack_up", {31'd0, proc_ack}, 32'd1);
        rd = rx_exp_q.pop_front();
        check("stall_din", {24'd0, proc_din}, {24'd0, rd});
        check("stall_no_pop", {29'd0, rx_count}, 32'd1);
        proc_req = 1'b0;
        step();
        rx_cnt_m = 0;
        check("stall_ack_down", {31'd0, proc_ack}, 32'd0);
        check("stall_pop", {29'd0, rx_count}, 32'd0);
        step();
        check("din_hold", {24'd0, proc_din}, 32'h3C);

        // Fill RX past full, then read across the pointer wrap.
        for (int i = 1; i <= 6; i++) host_rx_push(8'(i));
        check("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        core_xfer(1'b0, 8'h00, lat);
        host_rx_push(8'h05);
        core_xfer(1'b0, 8'h00, lat);
        host_rx_push(8'h06);
        for (int i = 0; i < 4; i++) core_xfer(1'b0, 8'h00, lat);
        check("rx_drained", {29'd0, rx_count}, 32'd0);

        // TX full: host pop and core OUT in the same cycle.
        for (int i = 0; i < 4; i++) core_xfer(1'b1, 8'h10 + 8'(i), lat);
        check("tx_full_count", {29'd0, tx_count}, 32'd4);
        check("sim_head", {24'd0, tx_data}, {24'd0, tx_exp_q[0]});
        tx_ready = 1'b1; proc_wr = 1'b1; proc_dout = 8'h14; proc_req = 1'b1;
        step();
        tx_ready = 1'b0;
        rd = tx_exp_q.pop_front();
        tx_cnt_m--;
        check("sim_no_ack", {31'd0, proc_ack}, 32'd0);
        check("sim_count3", {29'd0, tx_count}, tx_cnt_m);
        step();
        check("sim_ack", {31'd0, proc_ack}, 32'd1);
        tx_exp_q.push_back(8'h14); tx_cnt_m++;
        check("sim_count4", {29'd0, tx_count}, tx_cnt_m);
        proc_req = 1'b0;
        step();
        step();
        while (tx_exp_q.size() > 0) host_tx_pop();

        // Random OUT bytes through the TX path.
        for (int i = 0; i < 3; i++) core_xfer(1'b1, 8'($urandom_range(0, 255)), lat);
        while (tx_exp_q.size() > 0) host_tx_pop();

        // Reset during RD_ACK aborts; a fresh handshake then works.
        host_rx_push(8'hAA);
        host_rx_push(8'hBB);
        proc_wr = 1'b0; proc_req = 1'b1;
        step();
        check("abort_ack_up", {31'd0, proc_ack}, 32'd1);
        check("abort_din", {24'd0, proc_din}, 32'hAA);
        #2 g_clr = 1'b1;
        #1;
        check("abort_ack", {31'd0, proc_ack}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("abort_rx_count", {29'd0, rx_count}, 32'd0);
        check("abort_rx_ready", {31'd0, rx_ready}, 32'd1);
        proc_req = 1'b0;
        step();
        g_clr = 1'b0;
        rx_exp_q.delete(); rx_cnt_m = 0;
        step();
        host_rx_push(8'h77);
        core_xfer(1'b0, 8'h00, lat);
        check("rehsk_lat", lat, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
